// File: rtl/fp_div_seq.sv
// fp_div_seq: iterative floating-point divider, one restoring quotient bit per cycle,
// valid/ready on both sides. Define FP_DIV_RNE_EN for round-to-nearest-even, else truncation.
module fp_div_seq #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic                   Exception
);
   localparam int unsigned W  = 1 + EXP_W + MAN_W;
   localparam int unsigned Q  = MAN_W + 3;
   localparam int unsigned EW = EXP_W + 2;
   localparam int unsigned CW = $clog2(Q);

   localparam logic signed [EW-1:0] BiasS = EW'((2 ** (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] MaxS  = EW'((2 ** EXP_W) - 1);
   localparam logic signed [EW-1:0] ZeroS = '0;
   localparam logic signed [EW-1:0] OneS  = EW'(1);
   localparam logic [W-1:0] QNaN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

`ifdef FP_DIV_RNE_EN
   localparam bit RneEn = 1'b1;
`else
   localparam bit RneEn = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StCalc, StNorm, StDone} state_e;

   state_e                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [MAN_W+1:0]       rem_q, rem_d;
   logic [MAN_W:0]         div_q, div_d;
   logic [Q-1:0]           quo_q, quo_d;
   logic signed [EW-1:0]   exp_q, exp_d;
   logic                   sign_q, sign_d;
   logic [W-1:0]           result_q, result_d;
   logic                   exc_q, exc_d;

   logic [EXP_W-1:0]       ea, eb;
   logic [MAN_W-1:0]       fa, fb;
   logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s_in;
   logic [MAN_W+2:0]       trial;
   logic                   ge;
   logic [MAN_W+1:0]       rem_nx;
   logic [Q-1:0]           norm;
   logic signed [EW-1:0]   e1, e2;
   logic [MAN_W-1:0]       frac;
   logic                   guard, rnd, sticky, inc;
   logic [MAN_W:0]         sum;

   always_comb begin
      ea     = a[W-2:MAN_W];
      eb     = b[W-2:MAN_W];
      fa     = a[MAN_W-1:0];
      fb     = b[MAN_W-1:0];
      s_in   = a[W-1] ^ b[W-1];
      a_nan  = (&ea) && (|fa);
      b_nan  = (&eb) && (|fb);
      a_inf  = (&ea) && !(|fa);
      b_inf  = (&eb) && !(|fb);
      // Zero exponent covers subnormals, which are flushed to zero.
      a_zero = !(|ea);
      b_zero = !(|eb);
   end

   always_comb begin
      trial  = {1'b0, rem_q} - {2'b00, div_q};
      ge     = ~trial[MAN_W+2];
      rem_nx = ge ? trial[MAN_W+1:0] : rem_q;

      norm   = quo_q[Q-1] ? quo_q : {quo_q[Q-2:0], 1'b0};
      e1     = quo_q[Q-1] ? exp_q : exp_q - OneS;
      frac   = norm[Q-2:2];
      guard  = norm[1];
      rnd    = norm[0];
      sticky = |rem_q;
      inc    = RneEn & guard & (rnd | sticky | frac[0]);
      sum    = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
      // Rounding carry renormalises to 1.0 with the exponent bumped.
      e2     = sum[MAN_W] ? e1 + OneS : e1;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      div_d    = div_q;
      quo_d    = quo_q;
      exp_d    = exp_q;
      sign_d   = sign_q;
      result_d = result_q;
      exc_d    = exc_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               sign_d = s_in;
               cnt_d  = '0;
               rem_d  = {2'b01, fa};
               div_d  = {1'b1, fb};
               quo_d  = '0;
               exp_d  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BiasS;
               if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                  result_d = QNaN;
                  exc_d    = 1'b1;
                  state_d  = StDone;
               end else if (a_inf || b_zero) begin
                  result_d = {s_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  exc_d    = 1'b1;
                  state_d  = StDone;
               end else if (a_zero || b_inf) begin
                  result_d = {s_in, {(W - 1){1'b0}}};
                  exc_d    = 1'b0;
                  state_d  = StDone;
               end else begin
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            rem_d = rem_nx << 1;
            quo_d = {quo_q[Q-2:0], ge};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(Q - 1)) state_d = StNorm;
         end
         StNorm: begin
            state_d = StDone;
            if (e2 >= MaxS) begin
               result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               exc_d    = 1'b1;
            end else if (e2 <= ZeroS) begin
               result_d = {sign_q, {(W - 1){1'b0}}};
               exc_d    = 1'b1;
            end else begin
               result_d = {sign_q, e2[EXP_W-1:0], sum[MAN_W-1:0]};
               exc_d    = 1'b0;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         rem_q    <= '0;
         div_q    <= '0;
         quo_q    <= '0;
         exp_q    <= '0;
         sign_q   <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         div_q    <= div_d;
         quo_q    <= quo_d;
         exp_q    <= exp_d;
         sign_q   <= sign_d;
         result_q <= result_d;
         exc_q    <= exc_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign result    = result_q;
   assign Exception = exc_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: driver queues expected results, a monitor pops and compares.
module tb_fp_div_seq;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        Exception;

   always #5 clk = ~clk;

   fp_div_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .Exception (Exception)
   );

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (!rst && in_valid && in_ready) acc_cyc <= cyc;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, got, want);
      end
   endtask

   task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] er,
                        input logic ee, input int el, input string nm);
      int g = 0;
      @(negedge clk);
      while (!in_ready && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL %s accept: in_ready stuck at 0, want 1", nm);
      end else begin
         a        = ia;
         b        = ib;
         in_valid = 1'b1;
         sb.push_back('{res: er, exc: ee, lat: el, name: nm});
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int g = 0;
      while (sb.size() != 0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d results outstanding, want 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin : monitor
      exp_t e;
      int   lat;
      logic prev_v;
      prev_v = 1'b0;
      lat = 0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            prev_v = 1'b0;
         end else begin
            if (out_valid) begin
               if (!prev_v) lat = cyc - acc_cyc;
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL spurious: out_valid with result 0x%08h, want no output", result);
               end else if (!out_ready) begin
                  chk({sb[0].name, " hold"}, result, sb[0].res);
               end else begin
                  e = sb.pop_front();
                  chk({e.name, " result"}, result, e.res);
                  chk({e.name, " exc"}, {31'b0, Exception}, {31'b0, e.exc});
                  chk({e.name, " latency"}, lat, e.lat);
               end
            end
            prev_v = out_valid;
         end
      end
   end

   initial begin : driver
      int g;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      repeat (3) @(negedge clk);
      chk("reset in_ready", {31'b0, in_ready}, 32'd1);
      chk("reset out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset result", result, 32'h0);
      chk("reset exc", {31'b0, Exception}, 32'd0);
      rst = 1'b0;

      issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28, "6/2");
      drain();
`ifdef FP_DIV_RNE_EN
      issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 28, "1/3");
      drain();
      issue(32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, 1'b0, 28, "1/1.5");
      drain();
`else
      issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 28, "1/3");
      drain();
      issue(32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 1'b0, 28, "1/1.5");
      drain();
`endif
      issue(32'hC1000000, 32'h40000000, 32'hC0800000, 1'b0, 28, "-8/2");
      drain();
      issue(32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b1, 28, "overflow");
      drain();
      issue(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 1'b0, 28, "max/1");
      drain();
      issue(32'h00800000, 32'h40000000, 32'h00000000, 1'b1, 28, "underflow");
      drain();
      issue(32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 1, "0/0");
      drain();
      issue(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1, "1/0");
      drain();
      issue(32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b1, 1, "nan/1");
      drain();
      issue(32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b1, 1, "inf/-inf");
      drain();
      issue(32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b1, 1, "inf/-2");
      drain();
      issue(32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 1, "-0/5");
      drain();
      issue(32'h40400000, 32'hFF800000, 32'h80000000, 1'b0, 1, "3/-inf");
      drain();
      issue(32'hBF800000, 32'h80000000, 32'h7F800000, 1'b1, 1, "-1/-0");
      drain();
      issue(32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1, "subnormal/1");
      drain();

      // Backpressure: result must stay put while out_ready is low.
      out_ready = 1'b0;
      issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28, "6/2 stall");
      g = 0;
      while (!out_valid && g < 100) begin
         @(negedge clk);
         g++;
      end
      repeat (10) @(negedge clk);
      out_ready = 1'b1;
      drain();

      // A second request while busy must be ignored.
      issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28, "6/2 busy");
      repeat (5) @(negedge clk);
      a        = 32'h3F800000;
      b        = 32'h40400000;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      drain();

      // Reset mid-CALC discards the operation.
      issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28, "aborted");
      repeat (5) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("abort in_ready", {31'b0, in_ready}, 32'd1);
      chk("abort out_valid", {31'b0, out_valid}, 32'd0);
      rst = 1'b0;
      issue(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28, "6/2 after reset");
      drain();
      repeat (40) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
